// File: rtl/enb_burst_gen.sv
// Programmable, registered enable-burst source for the clock enabler.
// Optional abort input is compiled in when ENB_ABORT_EN is defined.
module enb_burst_gen #(
  parameter int CNT_W = 8,
  parameter int NB_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [NB_W-1:0]  num_bursts,
`ifdef ENB_ABORT_EN
  input  logic             abort,
`endif
  output logic             enb,
  output logic             busy,
  output logic             done,
  output logic [NB_W-1:0]  bursts_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] bl_r, gl_r;
  logic [NB_W-1:0]  nb_r, bd_nxt_s;
  logic             enb_nxt_s, busy_nxt_s, done_nxt_s;
  logic             load_s, burst_end_s, last_burst_s, abort_hit_s;

`ifdef ENB_ABORT_EN
  assign abort_hit_s = abort && ((state_r == ON) || (state_r == OFF));
`else
  assign abort_hit_s = 1'b0;
`endif

  assign load_s       = (state_r == IDLE) && start;
  assign last_burst_s = ((bursts_done + {{(NB_W-1){1'b0}}, 1'b1}) == nb_r);

  // State, latched configuration, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      bl_r        <= {CNT_W{1'b0}};
      gl_r        <= {CNT_W{1'b0}};
      nb_r        <= {NB_W{1'b0}};
      enb         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bursts_done <= {NB_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      enb         <= enb_nxt_s;
      busy        <= busy_nxt_s;
      done        <= done_nxt_s;
      bursts_done <= bd_nxt_s;
      if (load_s) begin
        bl_r <= burst_len;
        gl_r <= gap_len;
        nb_r <= num_bursts;
      end else begin
        bl_r <= bl_r;
        gl_r <= gl_r;
        nb_r <= nb_r;
      end
    end
  end

  // Next-state decode; abort takes priority over burst/gap completion
  always_comb begin
    state_nxt_s = state_r;
    burst_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((burst_len != {CNT_W{1'b0}}) && (num_bursts != {NB_W{1'b0}})) state_nxt_s = ON;
          else state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ON: begin
        if (abort_hit_s) begin
          state_nxt_s = DONE;
        end else if (cnt_r == bl_r) begin
          burst_end_s = 1'b1;
          if (last_burst_s) state_nxt_s = DONE;
          else if (gl_r == {CNT_W{1'b0}}) state_nxt_s = ON;
          else state_nxt_s = OFF;
        end else begin
          state_nxt_s = ON;
        end
      end
      OFF: begin
        if (abort_hit_s) state_nxt_s = DONE;
        else if (cnt_r == gl_r) state_nxt_s = ON;
        else state_nxt_s = OFF;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and cycle counter
  always_comb begin
    enb_nxt_s  = (state_nxt_s == ON);
    busy_nxt_s = (state_nxt_s == ON) || (state_nxt_s == OFF);
    done_nxt_s = (state_nxt_s == DONE);

    if (load_s) bd_nxt_s = {NB_W{1'b0}};
    else if (burst_end_s && (bursts_done != nb_r)) bd_nxt_s = bursts_done + {{(NB_W-1){1'b0}}, 1'b1};
    else bd_nxt_s = bursts_done;

    // Counter restarts at 1 on entry to ON/OFF and on each back-to-back burst
    if (!busy_nxt_s) cnt_nxt_s = {CNT_W{1'b0}};
    else if ((state_nxt_s != state_r) || burst_end_s) cnt_nxt_s = {{(CNT_W-1){1'b0}}, 1'b1};
    else cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_enb_burst_gen.sv
// Directed, table-driven bench for enb_burst_gen; abort sequence built when ENB_ABORT_EN is defined.
module tb_enb_burst_gen;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] burst_len, gap_len;
  logic [3:0] num_bursts;
`ifdef ENB_ABORT_EN
  logic       abort;
`endif
  logic       enb, busy, done;
  logic [3:0] bursts_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] bl;
    logic [7:0] gl;
    logic [3:0] nb;
    logic       e_enb;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_bd;
  } vec_t;

  vec_t tbl[$];

  enb_burst_gen #(.CNT_W(8), .NB_W(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
`ifdef ENB_ABORT_EN
    .abort(abort),
`endif
    .enb(enb), .busy(busy), .done(done), .bursts_done(bursts_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ee, input logic eb, input logic ed, input logic [3:0] ebd);
    chk({tag, ".enb"}, int'(enb), int'(ee));
    chk({tag, ".busy"}, int'(busy), int'(eb));
    chk({tag, ".done"}, int'(done), int'(ed));
    chk({tag, ".bursts_done"}, int'(bursts_done), int'(ebd));
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] b, input logic [7:0] g, input logic [3:0] n);
    reset = r; start = s; burst_len = b; gap_len = g; num_bursts = n;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic [7:0] b, input logic [7:0] g, input logic [3:0] n,
                     input logic ee, input logic eb, input logic ed, input logic [3:0] ebd);
    vec_t v;
    v.rst = r; v.st = s; v.bl = b; v.gl = g; v.nb = n;
    v.e_enb = ee; v.e_busy = eb; v.e_done = ed; v.e_bd = ebd;
    tbl.push_back(v);
  endtask

  initial begin
    int n_on;
    int dones;
    int cyc;
    reset = 1'b1; start = 1'b0; burst_len = 8'd0; gap_len = 8'd0; num_bursts = 4'd0;
`ifdef ENB_ABORT_EN
    abort = 1'b0;
`endif

    // reset for two cycles, then idle
    add(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    // burst 3, gap 2, 2 bursts; config inputs scrambled after acceptance
    add(1'b0, 1'b1, 8'd3, 8'd2, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b0, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b0, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b0, 1'b0, 1'b1, 4'd2);
    add(1'b0, 1'b0, 8'd9, 8'd9, 4'd9, 1'b0, 1'b0, 1'b0, 4'd2);
    // burst 2, gap 0, 3 bursts: six back-to-back enabled cycles
    add(1'b0, 1'b1, 8'd2, 8'd0, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd2);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd2);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3);
    // zero burst_len, then zero num_bursts: straight to DONE
    add(1'b0, 1'b1, 8'd0, 8'd1, 4'd4, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 8'd3, 8'd1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    // start held high: one IDLE cycle between sequences
    add(1'b0, 1'b1, 8'd1, 8'd0, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 8'd1, 8'd0, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, 1'b1, 8'd1, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1);
    add(1'b0, 1'b1, 8'd1, 8'd0, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].bl, tbl[i].gl, tbl[i].nb);
      chk_out($sformatf("vec%0d", i), tbl[i].e_enb, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_bd);
    end

    // reset mid-way through the second burst; a start re-pulse while busy is ignored
    step(1'b0, 1'b1, 8'd3, 8'd2, 4'd2);
    step(1'b0, 1'b1, 8'd1, 8'd0, 4'd1);
    chk_out("repulse", 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk_out("repulse_gap", 1'b0, 1'b1, 1'b0, 4'd1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk_out("burst2", 1'b1, 1'b1, 1'b0, 4'd1);
    step(1'b1, 1'b0, 8'd0, 8'd0, 4'd0);
    chk_out("midreset", 1'b0, 1'b0, 1'b0, 4'd0);
    dones = 0;
    n_on = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
      if (done) dones++;
      if (enb) n_on++;
    end
    chk("midreset_no_done", dones, 0);
    chk("midreset_no_enb", n_on, 0);

    // longest burst: 255 enabled cycles, single burst
    step(1'b0, 1'b1, 8'd255, 8'd0, 4'd1);
    n_on = 0;
    cyc = 0;
    while (!done && cyc < 400) begin
      if (enb) n_on++;
      step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
      cyc++;
    end
    chk("maxburst_timeout", int'(cyc < 400), 1);
    chk("maxburst_len", n_on, 255);
    chk("maxburst_bd", int'(bursts_done), 1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);

`ifdef ENB_ABORT_EN
    // abort during the gap after burst 1
    step(1'b0, 1'b1, 8'd3, 8'd2, 4'd2);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk_out("pre_abort", 1'b0, 1'b1, 1'b0, 4'd1);
    abort = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    abort = 1'b0;
    chk_out("abort", 1'b0, 1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    chk_out("post_abort", 1'b0, 1'b0, 1'b0, 4'd1);
    abort = 1'b1;
    step(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);
    abort = 1'b0;
    chk_out("abort_idle", 1'b0, 1'b0, 1'b0, 4'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
